execute_stage: RTL and testbench

- Pipeline stage directly downstream of instruction decode.
- Consumes the registered decode bundle: operands, immediate, ALU control, memory/write-back flags and PC+4.
- Selects operand B, performs the ALU operation and registers the result plus pass-through controls for the memory stage.
- Holds a small state machine so multi-cycle operations can stall decode, and supports a synchronous flush.

---
 rtl/execute_stage.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// Execute pipeline stage sitting directly behind instruction decode. Selects
// operand B (register or immediate), performs the ALU operation and registers
// the result together with the memory / write-back controls and PC+4 for the
// memory stage.
//
// Optional feature macro: EXECUTE_STAGE_MUL_EN
//   defined   -> alu_op 10 is a multi-cycle shift-add multiply handled by a
//                two-state FSM; busy stalls decode while it runs.
//   undefined -> no FSM or iteration counter; busy is tied 0 and alu_op 10
//                behaves as ADD with single-cycle latency.
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous reset, active-low
//   in_valid         decode bundle valid this cycle
//   flush            synchronous kill of in-flight and presented work
//   reg1_data        operand A
//   reg2_data        operand B (register) / store data
//   immediate        sign-extended immediate, low XLEN bits used
//   alu_src          1 = operand B from immediate, 0 = reg2_data
//   alu_op           operation code
//   write_back       register write-back request
//   mem_wr / mem_rd  store / load request
//   cnt_val_pl4_in   PC+4 of the instruction
//   busy             multi-cycle op occupies the stage, upstream must hold
//   out_valid        registered result valid
//   alu_result       registered ALU result
//   store_data       registered reg2_data
//   zero             registered (alu_result == 0)
//   write_back_out, mem_wr_out, mem_rd_out
//                    registered controls, 0 whenever out_valid is 0
//   cnt_val_pl4_out  registered PC+4
//
// FSM (only with EXECUTE_STAGE_MUL_EN)
//   state  | meaning
//   IDLE   | accepting bundles, single-cycle ops complete here
//   MUL    | iterative multiply running, one shift-add per cycle
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] reg1_data,
  input  logic [XLEN-1:0] reg2_data,
  input  logic [63:0]     immediate,
  input  logic            alu_src,
  input  logic [3:0]      alu_op,
  input  logic            write_back,
  input  logic            mem_wr,
  input  logic            mem_rd,
  input  logic [31:0]     cnt_val_pl4_in,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic            zero,
  output logic            write_back_out,
  output logic            mem_wr_out,
  output logic            mem_rd_out,
  output logic [31:0]     cnt_val_pl4_out
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic [XLEN-1:0] w_op_b;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;

  logic            r_out_valid;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_store_data;
  logic            r_zero;
  logic            r_wb;
  logic            r_mw;
  logic            r_mr;
  logic [31:0]     r_pc4;

  // Upper immediate bits are architecturally ignored at this width.
  generate
    if (XLEN < 64) begin : g_imm_hi
      logic w_unused_imm_hi;
      assign w_unused_imm_hi = ^immediate[63:XLEN];
    end
  endgenerate

  assign w_op_b  = alu_src ? immediate[XLEN-1:0] : reg2_data;
  assign w_shamt = w_op_b[SHW-1:0];

  // Single-cycle ALU; unlisted codes (including 10 when the multiplier is
  // absent) fall through to ADD.
  always_comb begin
    w_alu = reg1_data + w_op_b;
    case (alu_op)
      OP_ADD:  w_alu = reg1_data + w_op_b;
      OP_SUB:  w_alu = reg1_data - w_op_b;
      OP_AND:  w_alu = reg1_data & w_op_b;
      OP_OR:   w_alu = reg1_data | w_op_b;
      OP_XOR:  w_alu = reg1_data ^ w_op_b;
      OP_SLL:  w_alu = reg1_data << w_shamt;
      OP_SRL:  w_alu = reg1_data >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(reg1_data) >>> w_shamt);
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(reg1_data) < $signed(w_op_b))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (reg1_data < w_op_b)};
      default: ;
    endcase
  end

`ifdef EXECUTE_STAGE_MUL_EN
  localparam logic [3:0]     OP_MUL   = 4'd10;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_busy;
  logic            w_mul_start;
  logic            w_mul_last;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_acc_nxt;
  logic            r_mul_wb;
  logic            r_mul_mw;
  logic            r_mul_mr;
  logic [XLEN-1:0] r_mul_store;
  logic [31:0]     r_mul_pc4;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush wins over both acceptance and completion.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_mul_start) w_state_nxt = S_MUL;
        S_MUL:  if (w_mul_last)  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_busy = 1'b0;
    if (r_state == S_MUL) w_busy = 1'b1;
  end

  assign busy        = w_busy;
  assign w_mul_start = (r_state == S_IDLE) && in_valid && (alu_op == OP_MUL);
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CNT_LAST);

  // Shift-add step: multiplicand moves left, multiplier right; only the low
  // XLEN product bits are ever needed, so everything stays XLEN wide.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_mul_wb    <= 1'b0;
      r_mul_mw    <= 1'b0;
      r_mul_mr    <= 1'b0;
      r_mul_store <= '0;
      r_mul_pc4   <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= w_mul_last ? '0 : r_cnt + SHW'(1);
    end else if (w_mul_start) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= reg1_data;
      r_mplier    <= w_op_b;
      r_mul_wb    <= write_back;
      r_mul_mw    <= mem_wr;
      r_mul_mr    <= mem_rd;
      r_mul_store <= reg2_data;
      r_mul_pc4   <= cnt_val_pl4_in;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Result / control registers toward the memory stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_zero       <= 1'b0;
      r_wb         <= 1'b0;
      r_mw         <= 1'b0;
      r_mr         <= 1'b0;
      r_pc4        <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_wb        <= 1'b0;
      r_mw        <= 1'b0;
      r_mr        <= 1'b0;
`ifdef EXECUTE_STAGE_MUL_EN
    end else if (w_busy) begin
      // in_valid is ignored here; upstream is stalled by busy.
      r_out_valid <= w_mul_last;
      r_wb        <= w_mul_last & r_mul_wb;
      r_mw        <= w_mul_last & r_mul_mw;
      r_mr        <= w_mul_last & r_mul_mr;
      if (w_mul_last) begin
        r_alu_result <= w_acc_nxt;
        r_zero       <= (w_acc_nxt == '0);
        r_store_data <= r_mul_store;
        r_pc4        <= r_mul_pc4;
      end
    end else if (w_mul_start) begin
      r_out_valid <= 1'b0;
      r_wb        <= 1'b0;
      r_mw        <= 1'b0;
      r_mr        <= 1'b0;
`endif
    end else if (in_valid) begin
      r_out_valid  <= 1'b1;
      r_alu_result <= w_alu;
      r_zero       <= (w_alu == '0);
      r_store_data <= reg2_data;
      r_wb         <= write_back;
      r_mw         <= mem_wr;
      r_mr         <= mem_rd;
      r_pc4        <= cnt_val_pl4_in;
    end else begin
      r_out_valid <= 1'b0;
      r_wb        <= 1'b0;
      r_mw        <= 1'b0;
      r_mr        <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign alu_result      = r_alu_result;
  assign store_data      = r_store_data;
  assign zero            = r_zero;
  assign write_back_out  = r_wb;
  assign mem_wr_out      = r_mw;
  assign mem_rd_out      = r_mr;
  assign cnt_val_pl4_out = r_pc4;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus a randomized
// stream of single-cycle operations compared against a behavioural model.
module tb_execute_stage;
  localparam int XLEN = 32;
`ifdef EXECUTE_STAGE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, alu_src, write_back, mem_wr, mem_rd;
  logic [31:0] reg1_data, reg2_data, cnt_val_pl4_in;
  logic [63:0] immediate;
  logic [3:0]  alu_op;
  logic        busy, out_valid, zero, write_back_out, mem_wr_out, mem_rd_out;
  logic [31:0] alu_result, store_data, cnt_val_pl4_out;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .reg1_data(reg1_data), .reg2_data(reg2_data), .immediate(immediate),
    .alu_src(alu_src), .alu_op(alu_op), .write_back(write_back),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .cnt_val_pl4_in(cnt_val_pl4_in),
    .busy(busy), .out_valid(out_valid), .alu_result(alu_result),
    .store_data(store_data), .zero(zero), .write_back_out(write_back_out),
    .mem_wr_out(mem_wr_out), .mem_rd_out(mem_rd_out),
    .cnt_val_pl4_out(cnt_val_pl4_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sb;
    int unsigned s;
    logic [31:0] r, ones;
    sa   = a;
    sb   = b;
    s    = b % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: begin
        r = a >> s;
        if (a[31]) r = r | ~(ones >> s);
        return r;
      end
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      4'd10: return MUL_EN ? a * b : a + b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 7));
      1:       return 32'h8000_0000 | 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; alu_src = 0; write_back = 0; mem_wr = 0; mem_rd = 0;
    reg1_data = 0; reg2_data = 0; immediate = 0; alu_op = 0; cnt_val_pl4_in = 0;
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom); flush = 1'($urandom); alu_src = 1'($urandom);
    write_back = 1'($urandom); mem_wr = 1'($urandom); mem_rd = 1'($urandom);
    reg1_data = $urandom; reg2_data = $urandom; immediate = {$urandom, $urandom};
    alu_op = 4'($urandom); cnt_val_pl4_in = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_res"}, alu_result, 0);
    check({tag, "_store"}, store_data, 0);
    check({tag, "_zero"}, zero, 0);
    check({tag, "_ctl"}, {write_back_out, mem_wr_out, mem_rd_out}, 0);
    check({tag, "_pc4"}, cnt_val_pl4_out, 0);
  endtask

  // One single-cycle op: apply, clock, compare against the model.
  task automatic single_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res);
    in_valid = 1; flush = 0; alu_src = 0; alu_op = op; reg1_data = a; reg2_data = b;
    write_back = 1; mem_wr = 0; mem_rd = 0; cnt_val_pl4_in = 32'h40;
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, alu_result, exp_res);
    check({tag, "_zero"}, zero, exp_res == 0);
  endtask

`ifdef EXECUTE_STAGE_MUL_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res);
    int lat, busy_n;
    in_valid = 1; flush = 0; alu_src = 0; alu_op = 4'd10; reg1_data = a; reg2_data = b;
    write_back = 1; mem_wr = 0; mem_rd = 0; cnt_val_pl4_in = 32'h200;
    step();
    check({tag, "_accept_valid"}, out_valid, 0);
    busy_n = busy ? 1 : 0;
    // A distracting bundle held on the inputs must be ignored while busy.
    alu_op = 4'd0; reg1_data = 1; reg2_data = 1; cnt_val_pl4_in = 32'h300;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 20) in_valid = 0;
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
    end
    check({tag, "_latency"}, lat, 32);
    check({tag, "_busy_cycles"}, busy_n, 32);
    check({tag, "_res"}, alu_result, exp_res);
    check({tag, "_zero"}, zero, exp_res == 0);
    check({tag, "_wb"}, write_back_out, 1);
    check({tag, "_pc4"}, cnt_val_pl4_out, 32'h200);
    check({tag, "_busy_done"}, busy, 0);
    step();
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask
`endif

  initial begin
    logic        exp_v;
    logic [31:0] exp_res, b;
    int          seen;

    // Reset held with random inputs.
    rst = 0;
    rand_inputs();
    #2;
    check_all_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
    end
    check_all_zero("rst_hold");
    set_idle();
    rst = 1;
    #2;
    check_all_zero("rst_release");

    // ADD with immediate.
    in_valid = 1; alu_src = 1; alu_op = 0; reg1_data = 32'h10;
    immediate = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("add_imm_valid", out_valid, 1);
    check("add_imm_res", alu_result, 32'h0000_000C);
    check("add_imm_zero", zero, 0);

    single_op("sub", 4'd1, 5, 5, 32'h0);
    single_op("sra", 4'd7, 32'h8000_0000, 4, 32'hF800_0000);
    single_op("slt", 4'd8, 32'hFFFF_FFFF, 1, 32'h1);
    single_op("sltu", 4'd9, 32'hFFFF_FFFF, 1, 32'h0);
`ifndef EXECUTE_STAGE_MUL_EN
    single_op("op10_add", 4'd10, 32'h0001_2345, 32'h100, 32'h0001_2445);
    check("op10_busy", busy, 0);
`endif

    // Pass-through of store data, controls and PC+4.
    in_valid = 1; alu_src = 0; alu_op = 0; write_back = 0; mem_wr = 1; mem_rd = 0;
    reg1_data = 32'h3; reg2_data = 32'hDEAD_BEEF; cnt_val_pl4_in = 32'h104;
    step();
    check("pt_store", store_data, 32'hDEAD_BEEF);
    check("pt_memwr", mem_wr_out, 1);
    check("pt_pc4", cnt_val_pl4_out, 32'h104);
    check("pt_valid", out_valid, 1);
    in_valid = 0;
    step();
    check("pt_idle_valid", out_valid, 0);
    check("pt_idle_memwr", mem_wr_out, 0);

    // flush together with in_valid in IDLE.
    single_op("pre_flush", 4'd0, 1, 2, 32'h3);
    in_valid = 1; flush = 1; write_back = 1; mem_rd = 1;
    step();
    check("flush_idle_valid", out_valid, 0);
    check("flush_idle_wb", write_back_out, 0);
    check("flush_idle_rd", mem_rd_out, 0);
    flush = 0; in_valid = 0;

`ifdef EXECUTE_STAGE_MUL_EN
    run_mul("mul_a", 32'h0001_2345, 32'h0000_0100, 32'h0123_4500);
    run_mul("mul_b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Flush on cycle 10 of a MUL.
    in_valid = 1; alu_op = 4'd10; reg1_data = 7; reg2_data = 9; write_back = 1;
    step();
    in_valid = 0;
    for (int k = 1; k < 10; k++) step();
    flush = 1;
    step();
    flush = 0;
    check("flush_mul_busy", busy, 0);
    check("flush_mul_valid", out_valid, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid) seen++;
    end
    check("flush_mul_no_output", seen, 0);

    // Asynchronous reset in the middle of a MUL.
    in_valid = 1; alu_op = 4'd10; reg1_data = 32'h55; reg2_data = 32'h3;
    step();
    in_valid = 0;
    for (int k = 0; k < 5; k++) step();
    #2;
    rst = 0;
    #1;
    check_all_zero("rst_mid_mul");
    @(negedge clk);
    rst = 1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid) seen++;
    end
    check("rst_mid_mul_no_output", seen, 0);
`else
    // Asynchronous reset between clock edges after a valid result.
    single_op("pre_rst", 4'd0, 32'h1234, 32'h1, 32'h1235);
    in_valid = 1;
    #2;
    rst = 0;
    #1;
    check_all_zero("rst_mid_op");
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    step();
    check("rst_mid_op_after", out_valid, 0);
`endif

    // Randomized single-cycle stream with occasional flush.
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 9) == 0);
      alu_src    = 1'($urandom);
      write_back = 1'($urandom);
      mem_wr     = 1'($urandom);
      mem_rd     = 1'($urandom);
      reg1_data  = rnd_operand();
      reg2_data  = rnd_operand();
      immediate  = {$urandom, rnd_operand()};
      cnt_val_pl4_in = $urandom;
      do alu_op = 4'($urandom); while (MUL_EN && alu_op == 4'd10);
      b       = alu_src ? immediate[31:0] : reg2_data;
      exp_res = ref_alu(alu_op, reg1_data, b);
      exp_v   = in_valid && !flush;
      step();
      check("rnd_valid", out_valid, exp_v);
      check("rnd_ctl", {write_back_out, mem_wr_out, mem_rd_out},
            exp_v ? {write_back, mem_wr, mem_rd} : 3'b000);
      check("rnd_busy", busy, 0);
      if (exp_v) begin
        check("rnd_res", alu_result, exp_res);
        check("rnd_zero", zero, exp_res == 0);
        check("rnd_store", store_data, reg2_data);
        check("rnd_pc4", cnt_val_pl4_out, cnt_val_pl4_in);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
